instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: it consumes the word-addressed instruction stream starting at the program counter, issues read requests to instruction memory, buffers returned words in an in-order prefetch queue, and presents them with their addresses to decode. It sits between the program counter / branch logic (which supplies redirects) and the decode stage. It is the reader side of the PC-addressed instruction interface.

## Interface
- `DEPTH`, 4: prefetch queue entries; also the maximum number of requests in flight (power of 2, ≥2).
- `RESET_PC`, 32'h0: first fetch address after reset.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low. One clock; no other clock domains.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address (word address).
- `mem_req_valid` out 1: read request valid.
- `mem_req_addr` out 32: read word address; equals internal fetch PC.
- `mem_req_ready` in 1: memory accepts request this cycle.
- `mem_rsp_valid` in 1: read data returning; responses in request order, no backpressure.
- `mem_rsp_data` in 32: read data.
- `inst_valid` out 1: instruction available to decode.
- `inst_data` out 32: instruction word.
- `inst_pc` out 32: word address of `inst_data`.
- `inst_ready` in 1: decode accepts instruction this cycle.

## Operation
- Registers: fetch PC; queue of DEPTH entries {pc, data, filled}; write/read/fill pointers; `alloc` count (0..DEPTH, entries allocated including unfilled); `drop` count (0..DEPTH, stale responses still owed).
- Credit: `mem_req_valid = !redirect && (alloc + drop < DEPTH)`, while `rst` is high; forced 0 while `rst` is low.
- Request handshake: transfers only when `mem_req_valid && mem_req_ready` in the same cycle. On transfer: allocate tail entry with pc = fetch PC, filled = 0; fetch PC <= fetch PC + 1 mod 2^32 (32'hFFFFFFFF wraps to 0). Without ready, the address is held unchanged.
- Response: if `drop > 0`, discard data and `drop--`. Otherwise write data into the oldest unfilled entry and set filled.
- Output: `inst_valid` = head allocated and filled; `inst_data`/`inst_pc` = head fields. Pop on `inst_valid && inst_ready`, `alloc--`.
- Implicit modes: RUN (`drop == 0`), DRAIN (`drop > 0`; requests are still permitted within credit, new entries fill only after drop reaches 0).
- Redirect at cycle N: no request transfers in N. At the edge, fetch PC <= `redirect_pc`; queue emptied (`alloc` = 0, pointers reset). `drop` <= `drop` + (unfilled entries) − (1 if a response arrived in N). A response in N is always treated as stale. A pop in N completes normally; decode owns that instruction.
- `alloc` and `drop` each handle simultaneous increment and decrement in one cycle (net 0).
- Never overflows: an allocation cannot happen when `alloc + drop == DEPTH`. A response with `drop == 0` and no unfilled entry is a protocol error; it is ignored and a simulation assertion fires.

## Timing
- Reset values (asynchronous, take effect immediately): fetch PC = RESET_PC, `mem_req_valid` = 0, `mem_req_addr` = RESET_PC, `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `alloc` = `drop` = 0.
- First cycle after `rst` rises: `mem_req_valid` = 1, `mem_req_addr` = RESET_PC.
- Sustained throughput: 1 request/cycle when `mem_req_ready` = 1 and decode keeps up.
- Response in cycle N → `inst_valid` in N+1 at the earliest (registered queue). There is no combinational path from `mem_rsp_*` to `inst_*`.
- Redirect in cycle N → `inst_valid` = 0 and `mem_req_addr` = `redirect_pc` in N+1. `mem_req_valid` in N+1 depends on credit.
- `mem_req_valid` depends combinationally on `redirect` only; it does not depend on ready.
- Reset asserted mid-operation: all state cleared at once. In-flight responses after reset release are the system's responsibility; memory is reset together with this block.

## Test plan
- Reset release; `mem_req_ready` = 1; memory replies 1 cycle after accept with data = ~addr; `inst_ready` = 1 → requests at 0, 1, 2, …; `inst_pc` 0, 1, 2, … with `inst_data` = ~pc, one per cycle after a 2-cycle startup.
- `inst_ready` = 0, DEPTH = 4 → exactly 4 requests (0–3) transfer, then `mem_req_valid` = 0. Raise `inst_ready` → pops 0–3 in order; next request addr 4 in the cycle after the first pop.
- Memory latency 3; after 3 requests (0–2) are outstanding, pulse `redirect` with `redirect_pc` = 32'h100 → the 3 stale responses are discarded; first `inst_valid` shows `inst_pc` = 32'h100; no pc 0–2 is ever presented after the redirect.
- Redirect to 32'hFFFFFFFF → request addresses 32'hFFFFFFFF then 32'h00000000; `inst_pc` follows the same order.
- `mem_req_ready` pattern 0,0,1,0,1 → `mem_req_addr` stays 0 for 3 cycles, then holds 1 across the stall; exactly 2 transfers (addr 0, 1).
- Drive `rst` low mid-stream with `alloc` = 3 → `inst_valid` and `mem_req_valid` drop to 0 the same cycle. After release, the first request is addr RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response, decode handoff.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads from the fetch PC, holds returned words in an
// in-order prefetch queue and hands them to decode; redirects flush and discard stale data.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]    fetch_pc;
  logic [31:0]    pc_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0]  wr_ptr, rd_ptr, fill_ptr;
  logic [CW-1:0]  alloc, drop, pending;

  logic           req_valid, req_fire;
  logic           head_valid, pop;
  logic           rsp_drop, rsp_fill;
  logic [CW:0]    used;
  logic [CW-1:0]  owed;
  logic [CW-1:0]  drop_on_redirect;

  // Credit counts both live entries and stale responses still owed by memory.
  assign used       = {1'b0, alloc} + {1'b0, drop};
  assign req_valid  = rst && !bus.redirect && (used < DEPTH_W);
  assign req_fire   = req_valid && bus.mem_req_ready;
  assign head_valid = (alloc != '0) && filled_q[rd_ptr];
  assign pop        = head_valid && bus.inst_ready;
  assign rsp_drop   = bus.mem_rsp_valid && (drop != '0);
  assign rsp_fill   = bus.mem_rsp_valid && (drop == '0) && (pending != '0);

  // On redirect every unfilled entry becomes a stale response; one arriving now is already paid.
  assign owed             = drop + pending;
  assign drop_on_redirect = (bus.mem_rsp_valid && (owed != '0)) ? owed - CW'(1) : owed;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = head_valid;
  assign bus.inst_data     = data_q[rd_ptr];
  assign bus.inst_pc       = pc_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      drop     <= '0;
      pending  <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      pending  <= '0;
      drop     <= drop_on_redirect;
    end else begin
      if (req_fire) begin
        pc_q[wr_ptr]     <= fetch_pc;
        filled_q[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + AW'(1);
        fetch_pc         <= fetch_pc + 32'd1;
      end
      // Responses fill strictly in request order, so the oldest unfilled slot is fill_ptr.
      if (rsp_fill) begin
        data_q[fill_ptr]   <= bus.mem_rsp_data;
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      alloc   <= alloc + CW'(req_fire) - CW'(pop);
      pending <= pending + CW'(req_fire) - CW'(rsp_fill);
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
    end
  end

  // A response nobody asked for means the memory side broke ordering or invented data.
  assert property (@(posedge clk) disable iff (!rst)
    !(bus.mem_rsp_valid && (drop == '0) && (pending == '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: a memory model answers requests and a
// reference stream (consecutive PCs from the last restart point) is matched against decode.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  instr_fetch_if bus_if();

  instr_fetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          check_count = 0;
  int          pass_count  = 0;
  int          cyc         = 0;
  int          pop_count   = 0;
  int          accept_count = 0;
  int          lat_min     = 1;
  int          lat_max     = 1;
  int          last_due    = 0;
  rsp_t        mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc    = RESET_PC;
  logic        redirect_seen = 1'b0;
  logic [31:0] redirect_target = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ~addr;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Memory: in-order responses, each at least its latency after acceptance.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mem_q.delete();
      last_due = 0;
      bus_if.mem_rsp_valid = 1'b0;
      bus_if.mem_rsp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_t r;
      r = mem_q.pop_front();
      bus_if.mem_rsp_valid = 1'b1;
      bus_if.mem_rsp_data  = r.data;
    end else begin
      bus_if.mem_rsp_valid = 1'b0;
      bus_if.mem_rsp_data  = '0;
    end
  end

  // Monitor: records accepted requests into the expected stream and checks every pop.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      model_pc      = RESET_PC;
      redirect_seen = 1'b0;
    end else begin
      if (redirect_seen) begin
        check_output("post_redirect_inst_valid", 32'(bus_if.inst_valid), 32'd0);
        check_output("post_redirect_addr", bus_if.mem_req_addr, redirect_target);
      end
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL pop_unexpected: got pc %h, expected no instruction", bus_if.inst_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("inst_pc", bus_if.inst_pc, e.pc);
          check_output("inst_data", bus_if.inst_data, e.data);
        end
      end
      if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
        rsp_t r;
        int   lat;
        accept_count++;
        check_output("req_addr", bus_if.mem_req_addr, model_pc);
        exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
        model_pc = model_pc + 32'd1;
        lat = $urandom_range(lat_max, lat_min);
        r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        r.data = mem_word(bus_if.mem_req_addr);
        last_due = r.due;
        mem_q.push_back(r);
      end
      if (bus_if.redirect) begin
        check_output("redirect_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
        exp_q.delete();
        model_pc = bus_if.redirect_pc;
      end
      redirect_seen   = bus_if.redirect;
      redirect_target = bus_if.redirect_pc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic req_ready, input logic dec_ready,
                             input int lmin, input int lmax);
    rst                  = 1'b0;
    bus_if.redirect      = 1'b0;
    bus_if.redirect_pc   = '0;
    bus_if.mem_req_ready = req_ready;
    bus_if.inst_ready    = dec_ready;
    lat_min              = lmin;
    lat_max              = lmax;
    sample();
    check_output("rst_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
    check_output("rst_req_addr", bus_if.mem_req_addr, RESET_PC);
    check_output("rst_inst_valid", 32'(bus_if.inst_valid), 32'd0);
    check_output("rst_inst_data", bus_if.inst_data, 32'd0);
    check_output("rst_inst_pc", bus_if.inst_pc, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic apply_stimulus();
    int          a0;
    int          p0;
    logic        found;
    logic        pat  [5];
    logic [31:0] addrs[5];
    logic [31:0] rpc;

    // Streaming: one instruction per cycle after a two-cycle startup.
    apply_reset(1'b1, 1'b1, 1, 1);
    p0 = pop_count;
    sample();
    check_output("first_req_valid", 32'(bus_if.mem_req_valid), 32'd1);
    check_output("first_req_addr", bus_if.mem_req_addr, RESET_PC);
    next_cycle();
    sample();
    check_output("startup_inst_valid_c1", 32'(bus_if.inst_valid), 32'd0);
    next_cycle();
    sample();
    check_output("startup_inst_valid_c2", 32'(bus_if.inst_valid), 32'd1);
    check_output("startup_inst_pc_c2", bus_if.inst_pc, RESET_PC);
    repeat (18) next_cycle();
    check_output("stream_pop_count", 32'(pop_count - p0), 32'd18);

    // Decode stalled: credit limits the unit to DEPTH outstanding entries.
    apply_reset(1'b1, 1'b0, 1, 1);
    a0 = accept_count;
    repeat (8) next_cycle();
    check_output("stall_accepts", 32'(accept_count - a0), 32'd4);
    sample();
    check_output("stall_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
    next_cycle();
    bus_if.inst_ready = 1'b1;
    sample();
    check_output("unstall_inst_valid", 32'(bus_if.inst_valid), 32'd1);
    check_output("unstall_inst_pc", bus_if.inst_pc, 32'd0);
    check_output("unstall_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
    next_cycle();
    sample();
    check_output("resume_req_valid", 32'(bus_if.mem_req_valid), 32'd1);
    check_output("resume_req_addr", bus_if.mem_req_addr, 32'd4);
    repeat (6) next_cycle();

    // Redirect with three requests outstanding at latency 3.
    apply_reset(1'b1, 1'b1, 3, 3);
    next_cycle();
    next_cycle();
    next_cycle();
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'h100;
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
    check_output("redir_inst_valid", 32'(bus_if.inst_valid), 32'd0);
    check_output("redir_req_addr", bus_if.mem_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_cycle();
      sample();
      if (bus_if.inst_valid) found = 1'b1;
    end
    check_output("redir_first_valid_seen", 32'(found), 32'd1);
    check_output("redir_first_pc", bus_if.inst_pc, 32'h100);
    lat_min = 1;
    lat_max = 1;
    repeat (10) next_cycle();

    // Redirect to the top of the address space: addresses wrap to zero.
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'hFFFF_FFFF;
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
    check_output("wrap_req_valid", 32'(bus_if.mem_req_valid), 32'd1);
    check_output("wrap_req_addr0", bus_if.mem_req_addr, 32'hFFFF_FFFF);
    next_cycle();
    sample();
    check_output("wrap_req_addr1", bus_if.mem_req_addr, 32'h0);
    repeat (10) next_cycle();

    // Memory backpressure: the address holds until accepted.
    pat   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    addrs = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    apply_reset(1'b0, 1'b1, 1, 1);
    a0 = accept_count;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      bus_if.mem_req_ready = pat[i];
      sample();
      check_output("bp_req_addr", bus_if.mem_req_addr, addrs[i]);
    end
    next_cycle();
    bus_if.mem_req_ready = 1'b0;
    check_output("bp_accepts", 32'(accept_count - a0), 32'd2);
    repeat (5) next_cycle();

    // Reset asserted mid-stream with three entries allocated.
    apply_reset(1'b1, 1'b0, 1, 1);
    next_cycle();
    next_cycle();
    next_cycle();
    bus_if.mem_req_ready = 1'b0;
    sample();
    check_output("midrst_pre_inst_valid", 32'(bus_if.inst_valid), 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    check_output("midrst_inst_valid", 32'(bus_if.inst_valid), 32'd0);
    check_output("midrst_req_valid", 32'(bus_if.mem_req_valid), 32'd0);
    next_cycle();
    apply_reset(1'b1, 1'b1, 1, 1);
    sample();
    check_output("midrst_first_req_valid", 32'(bus_if.mem_req_valid), 32'd1);
    check_output("midrst_first_req_addr", bus_if.mem_req_addr, RESET_PC);
    repeat (5) next_cycle();

    // Random traffic: backpressure both sides, variable latency, occasional redirects.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      bus_if.mem_req_ready = ($urandom_range(3, 0) != 0);
      bus_if.inst_ready    = ($urandom_range(3, 0) != 0);
      if ($urandom_range(39, 0) == 0) begin
        rpc = ($urandom_range(1, 0) == 0) ? $urandom : 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = rpc;
      end else begin
        bus_if.redirect = 1'b0;
      end
    end
    next_cycle();
    bus_if.redirect      = 1'b0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.inst_ready    = 1'b1;
    repeat (30) next_cycle();
    check_output("drain_expected_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst                  = 1'b0;
    bus_if.redirect      = 1'b0;
    bus_if.redirect_pc   = '0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.inst_ready    = 1'b0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_data  = '0;
    apply_stimulus();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end
endmodule
